// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package if_prefetch_queue_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned INST_W = 32;
   localparam int unsigned LEN_W  = 3;

   localparam logic [ADDR_W-1:0] IF_RESET_PC = 32'h0;
   localparam logic [1:0]        IF_PORT_ID  = 2'b01;

   typedef enum logic {
      IF_IDLE = 1'b0,
      IF_WAIT = 1'b1
   } if_state_e;

   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with flush; head is read straight from registered storage.
module if_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_head,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: one outstanding memory request, prefetching {pc, inst} into a queue.
module if_prefetch_queue
   import if_prefetch_queue_pkg::*;
#(
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter logic [31:0] RESET_PC    = IF_RESET_PC,
   parameter int unsigned INST_BYTES  = 4,
   parameter logic [1:0]  PORT_ID     = IF_PORT_ID
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        jump,
   input  logic [31:0] next_addr,
   output logic        re,
   output logic [31:0] fetch_addr,
   output logic [2:0]  len_in_byte,
   output logic [1:0]  port_id,
   input  logic        mem_busy,
   input  logic        mem_done,
   input  logic [31:0] inst_in,
   input  logic        id_ready,
   output logic        inst_valid,
   output logic [31:0] inst_pc,
   output logic [31:0] inst
);

   localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

   if_state_e   r_state, w_state_nxt;
   logic        r_re, w_re_nxt;
   logic [31:0] r_fetch_addr, w_fetch_addr_nxt;
   logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
   logic        r_discard, w_discard_nxt;
   logic [31:0] w_issue_pc;

   logic          w_push, w_pop, w_flush;
   logic [CW-1:0] w_count, w_count_nxt;
   logic          w_full, w_empty;
   logic [63:0]   w_head;
   logic          w_unused;

   assign w_push      = rdy_in && (r_state == IF_WAIT) && mem_done && !r_discard && !jump;
   assign w_pop       = rdy_in && !w_empty && id_ready && !jump;
   assign w_flush     = rdy_in && jump;
   assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

   // A jump wins over everything; an outstanding request is marked for discard
   // unless its response lands in the same cycle.
   always_comb begin
      w_state_nxt      = r_state;
      w_re_nxt         = r_re;
      w_fetch_addr_nxt = r_fetch_addr;
      w_fetch_pc_nxt   = r_fetch_pc;
      w_discard_nxt    = r_discard;
      w_issue_pc       = r_fetch_pc;
      if (jump) begin
         w_fetch_pc_nxt = align_pc(next_addr);
         if (r_state == IF_WAIT && !mem_done) begin
            w_discard_nxt = 1'b1;
         end else begin
            w_state_nxt   = IF_IDLE;
            w_re_nxt      = 1'b0;
            w_discard_nxt = 1'b0;
         end
      end else begin
         case (r_state)
            IF_IDLE: begin
               if (!w_full) begin
                  w_state_nxt      = IF_WAIT;
                  w_re_nxt         = 1'b1;
                  w_fetch_addr_nxt = r_fetch_pc;
               end
            end
            IF_WAIT: begin
               if (mem_done) begin
                  w_issue_pc     = r_discard ? r_fetch_pc : (r_fetch_pc + 32'(INST_BYTES));
                  w_fetch_pc_nxt = w_issue_pc;
                  w_discard_nxt  = 1'b0;
                  if (w_count_nxt < DEPTH_C) begin
                     w_re_nxt         = 1'b1;
                     w_fetch_addr_nxt = w_issue_pc;
                  end else begin
                     w_state_nxt = IF_IDLE;
                     w_re_nxt    = 1'b0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state      <= IF_IDLE;
         r_re         <= 1'b0;
         r_fetch_addr <= '0;
         r_fetch_pc   <= RESET_PC;
         r_discard    <= 1'b0;
      end else if (rdy_in) begin
         r_state      <= w_state_nxt;
         r_re         <= w_re_nxt;
         r_fetch_addr <= w_fetch_addr_nxt;
         r_fetch_pc   <= w_fetch_pc_nxt;
         r_discard    <= w_discard_nxt;
      end
   end

   if_fifo #(
      .WIDTH (64),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .i_clk   (clk_in),
      .i_rst   (rst_in),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  ({r_fetch_addr, inst_in}),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // mem_busy only lengthens the wait for mem_done, so the fetch logic never looks at it.
   assign w_unused = mem_busy;

   assign re          = r_re;
   assign fetch_addr  = r_fetch_addr;
   assign len_in_byte = LEN_W'(INST_BYTES);
   assign port_id     = PORT_ID;
   assign inst_valid  = !w_empty;
   assign inst_pc     = w_head[63:32];
   assign inst        = w_head[31:0];

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized scoreboard bench for if_prefetch_queue against a program-order fetch model.
module tb_if_prefetch_queue;

   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, jump, mem_busy, mem_done, id_ready;
   logic [31:0] next_addr, inst_in;
   logic        re, inst_valid;
   logic [31:0] fetch_addr, inst_pc, inst;
   logic [2:0]  len_in_byte;
   logic [1:0]  port_id;

   always #5 clk_in = ~clk_in;

   if_prefetch_queue #(
      .QUEUE_DEPTH (DEPTH),
      .RESET_PC    (RST_PC),
      .INST_BYTES  (4),
      .PORT_ID     (2'b01)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .jump        (jump),
      .next_addr   (next_addr),
      .re          (re),
      .fetch_addr  (fetch_addr),
      .len_in_byte (len_in_byte),
      .port_id     (port_id),
      .mem_busy    (mem_busy),
      .mem_done    (mem_done),
      .inst_in     (inst_in),
      .id_ready    (id_ready),
      .inst_valid  (inst_valid),
      .inst_pc     (inst_pc),
      .inst        (inst)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   entry_t      sb[$];
   logic [31:0] model_pc = RST_PC;
   logic [31:0] salt;
   bit          resp_keep = 1'b0;
   bit          mon_en = 1'b0;

   bit          pending = 1'b0;
   int unsigned lat = 0;
   logic [31:0] req_addr = '0;
   int unsigned epoch = 0, req_epoch = 0;
   bit          last_rdy = 1'b1, last_rst = 1'b1, last_jump = 1'b0;
   int unsigned idle_obs = 0;
   logic        snap_re, snap_valid;
   logic [31:0] snap_addr, snap_pc, snap_inst;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ salt;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: fetched words enter the queue in program order; a jump or reset empties it.
   initial forever begin
      @(posedge clk_in);
      if (rst_in) begin
         sb.delete();
         model_pc = RST_PC;
      end else if (rdy_in) begin
         if (jump) begin
            sb.delete();
            model_pc = {next_addr[31:2], 2'b00};
         end else if (mem_done && resp_keep) begin
            check("queue_room_at_push", 32'(sb.size() < DEPTH), 32'd1);
            sb.push_back({model_pc, memf(model_pc)});
            model_pc = model_pc + 32'd4;
         end
      end
   end

   // Monitor: compares the presented head and consumes it when decode takes it.
   initial forever begin
      @(negedge clk_in);
      if (mon_en) begin
         check("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
         if (sb.size() != 0) begin
            check("inst_pc", inst_pc, sb[0].pc);
            check("inst", inst, sb[0].data);
            if (!rst_in && rdy_in && !jump && id_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic drive_cycle(input int unsigned p_rdy, input int unsigned p_jump,
                              input int unsigned p_ready, input int unsigned p_rst);
      bit fire;
      @(posedge clk_in);
      #1;
      if (last_rst) begin
         check("rst_re", 32'(re), 32'd0);
         check("rst_fetch_addr", fetch_addr, 32'd0);
         check("rst_inst_valid", 32'(inst_valid), 32'd0);
         check("const_len", 32'(len_in_byte), 32'd4);
         check("const_port", 32'(port_id), 32'd1);
      end else if (!last_rdy) begin
         check("frz_re", 32'(re), 32'(snap_re));
         check("frz_fetch_addr", fetch_addr, snap_addr);
         check("frz_valid", 32'(inst_valid), 32'(snap_valid));
         check("frz_pc", inst_pc, snap_pc);
         check("frz_inst", inst, snap_inst);
      end
      if (!last_rst && !pending && re === 1'b1) begin
         check("req_addr", fetch_addr, model_pc);
         check("issue_room", 32'(sb.size() < DEPTH), 32'd1);
         pending   = 1'b1;
         req_addr  = fetch_addr;
         req_epoch = epoch;
         lat       = $urandom_range(0, 3);
      end
      if (last_rdy && !last_rst && !last_jump && !pending && re === 1'b0 && sb.size() < DEPTH)
         idle_obs++;
      else
         idle_obs = 0;
      check("issue_liveness", 32'(idle_obs > 2), 32'd0);
      if (idle_obs > 2) idle_obs = 0;
      snap_re = re; snap_addr = fetch_addr; snap_valid = inst_valid;
      snap_pc = inst_pc; snap_inst = inst;

      rst_in   = ($urandom_range(0, 99) < p_rst);
      rdy_in   = rst_in || ($urandom_range(0, 99) < p_rdy);
      id_ready = ($urandom_range(0, 99) < p_ready);
      mem_busy = 1'($urandom_range(0, 1));
      mem_done = 1'b0;
      jump     = 1'b0;
      fire     = 1'b0;
      if (!rst_in && rdy_in && pending) begin
         if (lat == 0) fire = 1'b1;
         else lat--;
      end
      if (!rst_in && rdy_in)
         jump = ($urandom_range(0, 99) < (fire ? 4 * p_jump : p_jump));
      next_addr = jump ? ($urandom & 32'h0000_0FFF) : $urandom;
      if (fire) begin
         mem_done  = 1'b1;
         inst_in   = memf(req_addr);
         resp_keep = !jump && (req_epoch == epoch);
         pending   = 1'b0;
      end else begin
         inst_in = $urandom;
      end
      if (jump) epoch++;
      if (rst_in) begin
         pending = 1'b0;
         epoch++;
      end
      last_rdy  = rdy_in;
      last_rst  = rst_in;
      last_jump = jump;
   endtask

   initial begin
      salt      = $urandom;
      rst_in    = 1'b1;
      rdy_in    = 1'b1;
      jump      = 1'b0;
      next_addr = '0;
      mem_busy  = 1'b0;
      mem_done  = 1'b0;
      inst_in   = '0;
      id_ready  = 1'b0;
      drive_cycle(100, 0, 100, 100);
      mon_en = 1'b1;
      repeat (2)   drive_cycle(100, 0, 100, 100);
      repeat (150) drive_cycle(100, 0, 100, 0);
      repeat (5)   drive_cycle(0,   0, 100, 0);
      repeat (50)  drive_cycle(100, 0, 100, 0);
      repeat (60)  drive_cycle(100, 0, 0,   0);
      drive_cycle(100, 0, 100, 0);
      repeat (20)  drive_cycle(100, 0, 0,   0);
      repeat (400) drive_cycle(100, 8, 60,  0);
      repeat (200) drive_cycle(100, 8, 10,  0);
      repeat (30)  drive_cycle(100, 0, 0,   0);
      drive_cycle(100, 0, 0, 100);
      repeat (30)  drive_cycle(100, 0, 100, 0);
      repeat (800) drive_cycle(80,  6, 50,  1);
      repeat (40)  drive_cycle(100, 0, 100, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
